test_port_capture: RTL and testbench
====================================

// Module: test_port_capture
// PURPOSE
// Bus-side front end of the result checker. Snoops the CPU data-memory write bus,
// isolates stores to the test port, collapses stores held across D-cache stalls into
// one event, converts little-endian bus data to readable order, and frames the
// result stream between begin/end symbols. Captured words reach the checker
// through a FIFO with a valid/ready handshake.
// PARAMETERS
// TEST_PORT  30'h3FF        word address of the test port
// BEGIN_SYM  32'h00000168   start-of-stream marker (readable order)
// END_SYM    32'hFFFFFD5D   end-of-stream marker (readable order)
// DEPTH      8              FIFO entries; power of two, >= 2
// CNT_W      16             width of cycle and word counters
// PORTS
// clk        in   1      clock; all state samples on posedge
// rst        in   1      asynchronous, active-low reset
// addr       in   30     data-memory word address
// data       in   32     store data, little-endian byte order
// wen        in   1      store strobe; may stay high for several cycles during a stall
// out_valid  out  1      FIFO head word valid
// out_data   out  32     FIFO head word, readable order
// out_last   out  1      head word is END_SYM
// out_ready  in   1      checker accepts head word when out_valid && out_ready
// capturing  out  1      high in CAPTURE state
// done       out  1      high in DONE state
// overflow   out  1      sticky: an event was dropped because the FIFO was full
// cycles     out  CNT_W  cycles spent in CAPTURE, saturating
// words      out  CNT_W  words pushed after BEGIN_SYM, END_SYM included, saturating
// BEHAVIOUR
// - Reset (async, rst low): state IDLE, FIFO empty; all outputs 0.
// - swap = {data[7:0],data[15:8],data[23:16],data[31:24]}.
// - Hold flag: set on any posedge with wen=1, cleared on posedge with wen=0. Each
//   wen=1 cycle that has the flag clear is a new store. event = new store && addr==TEST_PORT.
//   A store held over N stall cycles yields exactly one event.
// - FSM:
//   IDLE: event && swap==BEGIN_SYM -> CAPTURE; cycles, words, overflow cleared; BEGIN
//     word not pushed. Any other event is ignored.
//   CAPTURE: cycles += 1 each cycle, sticks at all-ones. Event -> push {swap, swap==END_SYM}.
//     A push of END_SYM moves to DONE in the same cycle, even if that push is dropped.
//     A BEGIN_SYM event in CAPTURE is pushed as ordinary data.
//   DONE: events ignored; cycles/words frozen; FIFO keeps draining. Exit only by reset.
// - FIFO: show-ahead. out_valid = !empty; out_data/out_last = head entry.
//   An event at posedge N makes out_valid high after posedge N, when the FIFO was empty.
//   A pop occurs on posedge with out_valid && out_ready.
//   Full && event && pop in the same cycle: push accepted; occupancy unchanged.
//   Full && event && no pop: word dropped; overflow set; words not incremented.
//   out_ready while empty: no effect.
// - words increments on each accepted push, saturating.
// - Pointers are log2(DEPTH) bits and wrap. Occupancy counter spans 0..DEPTH.
// TESTING
// - Reset, store BEGIN (bus data 32'h68010000) to 0x3FF, then stores 1,2,3 with
//   out_ready=1 -> out_data 1,2,3 in order; capturing=1; words=3.
// - Store of 5 to 0x3FF held for 4 stall cycles (wen high) -> exactly one push; words +1.
// - out_ready=0, DEPTH+2 events -> first DEPTH words kept, overflow=1, words=DEPTH.
//   Then drain -> exactly DEPTH words, original order.
// - FIFO full; event and pop in the same cycle -> no overflow; occupancy stays DEPTH.
// - Store END (bus data 32'h5DFDFFFF) -> out_last=1 on that word, done=1, cycles frozen.
//   Later stores ignored.
// - Stores to 0x3FE, and a non-BEGIN store to 0x3FF while IDLE -> no push, state IDLE.
//   Reset in CAPTURE with a non-empty FIFO -> IDLE, out_valid=0, counters 0.

Source files
------------

// File: rtl/test_port_capture.sv
// test_port_capture
// Bus-side front end of the result checker. Snoops the CPU data-memory write
// bus and isolates stores to the test port. A store held across D-cache stalls
// counts as one event. Bus data is byte-swapped into readable order. The
// result stream is framed between BEGIN_SYM and END_SYM, and words are handed
// to the checker through a show-ahead FIFO with a valid/ready handshake.
//
// Ports
//   clk        clock, all state samples on posedge
//   rst        asynchronous, active-low reset
//   addr       data-memory word address
//   data       store data, little-endian byte order
//   wen        store strobe, may stay high for several stall cycles
//   out_valid  FIFO head word valid
//   out_data   FIFO head word, readable order
//   out_last   head word is END_SYM
//   out_ready  checker accepts head word when out_valid && out_ready
//   capturing  high in CAPTURE state
//   done       high in DONE state
//   overflow   sticky, set when an event was dropped on a full FIFO
//   cycles     cycles spent in CAPTURE, saturating
//   words      words pushed after BEGIN_SYM (END_SYM included), saturating
module test_port_capture #(
  parameter logic [29:0] TEST_PORT = 30'h3FF,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      addr,
  input  logic [31:0]      data,
  input  logic             wen,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             capturing,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] words
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t state, next_state;

  logic             hold;
  logic [31:0]      swap;
  logic             evt;
  logic             is_begin;
  logic             is_end;
  logic             start;
  logic             push_req;
  logic             push_ok;
  logic             drop;
  logic             pop;
  logic             full;
  logic             empty;
  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign swap     = {data[7:0], data[15:8], data[23:16], data[31:24]};
  assign is_begin = (swap == BEGIN_SYM);
  assign is_end   = (swap == END_SYM);

  // Only the first cycle of a wen burst is a new store, so a store stretched
  // over a stall produces a single event.
  assign evt = wen && !hold && (addr == TEST_PORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold <= 1'b0;
    else      hold <= wen;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // BEGIN is only recognised from IDLE; once capturing, every event is data.
  // A pushed END closes the stream even if the FIFO had to drop it.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (evt && is_begin) begin
          next_state = CAPTURE;
          start      = 1'b1;
        end
      end
      CAPTURE: begin
        push_req = evt;
        if (evt && is_end) next_state = DONE;
      end
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign pop       = !empty && out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? 32'h0 : mem[rd_ptr][31:0];
  assign out_last  = empty ? 1'b0  : mem[rd_ptr][32];
  assign capturing = (state == CAPTURE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {is_end, swap};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Statistics restart on BEGIN and freeze in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles   <= '0;
      words    <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      cycles   <= '0;
      words    <= '0;
      overflow <= 1'b0;
    end else if (state == CAPTURE) begin
      if (cycles != '1)            cycles   <= cycles + 1'b1;
      if (push_ok && words != '1)  words    <= words + 1'b1;
      if (drop)                    overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_port_capture.sv
module tb_test_port_capture;

  localparam int DEPTH = 8;
  localparam logic [31:0] BEGIN_BUS = 32'h68010000;
  localparam logic [31:0] END_BUS   = 32'h5DFDFFFF;
  localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;

  logic        clk;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        capturing;
  logic        done;
  logic        overflow;
  logic [15:0] cycles;
  logic [15:0] words;

  int checks;
  int errors;
  int exp_words;
  logic [31:0] popped[$];

  test_port_capture dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data      (data),
    .wen       (wen),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .capturing (capturing),
    .done      (done),
    .overflow  (overflow),
    .cycles    (cycles),
    .words     (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word the checker side accepts, using pre-edge values.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) popped.push_back(out_data);
  end

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // One store held for n cycles, followed by at least one wen=0 cycle.
  task automatic bus_store(input logic [29:0] a, input logic [31:0] d, input int n);
    @(negedge clk);
    addr = a;
    data = d;
    wen  = 1'b1;
    repeat (n) @(negedge clk);
    wen  = 1'b0;
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; wen = 1'b0; addr = '0; data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
    checks++; if ({capturing, done, overflow} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {capturing, done, overflow}); end
    checks++; if ({cycles, words} !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters: got %h expected 0", {cycles, words}); end
    rst = 1'b1;
    exp_words = 0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    bus_store(30'h3FF, BEGIN_BUS, 1);
    checks++; if (capturing !== 1'b1) begin errors++; $display("[TB] FAIL begin_capturing: got %b expected 1", capturing); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL begin_not_pushed: got %b expected 0", out_valid); end
    for (int i = 1; i <= 3; i++) bus_store(30'h3FF, bswap(i), 1);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    exp_words = 3;
    checks++; if (popped.size() !== 3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", popped.size()); end
    for (int i = 0; i < popped.size() && i < 3; i++) begin
      checks++; if (popped[i] !== 32'(i + 1)) begin errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, popped[i], i + 1); end
    end
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL basic_words: got %0d expected %0d", words, exp_words); end
    checks++; if (capturing !== 1'b1) begin errors++; $display("[TB] FAIL basic_capturing: got %b expected 1", capturing); end
    popped.delete();
  endtask

  task automatic test_stall;
    bus_store(30'h3FF, bswap(32'd5), 4);
    exp_words++;
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL stall_words: got %0d expected %0d", words, exp_words); end
    checks++; if (out_data !== 32'd5 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL stall_head: got %h/%b expected 5/0", out_data, out_last); end
    drain(3);
    checks++; if (popped.size() !== 1) begin errors++; $display("[TB] FAIL stall_single_push: got %0d expected 1", popped.size()); end
    popped.delete();
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < DEPTH; i++) bus_store(30'h3FF, bswap(32'h20 + i), 1);
    exp_words += DEPTH;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_overflow: got %b expected 0", overflow); end
    // Event and pop on the same edge while full.
    @(negedge clk);
    addr = 30'h3FF; data = bswap(32'h20 + DEPTH); wen = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    wen = 1'b0; out_ready = 1'b0;
    exp_words++;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overflow: got %b expected 0", overflow); end
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL pushpop_words: got %0d expected %0d", words, exp_words); end
    checks++; if (out_data !== 32'h21) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected 21", out_data); end
    popped.delete();
    drain(DEPTH + 3);
    checks++; if (popped.size() !== DEPTH) begin errors++; $display("[TB] FAIL pushpop_drain_count: got %0d expected %0d", popped.size(), DEPTH); end
    for (int i = 0; i < popped.size() && i < DEPTH; i++) begin
      checks++; if (popped[i] !== 32'h21 + 32'(i)) begin errors++; $display("[TB] FAIL pushpop_word%0d: got %h expected %h", i, popped[i], 32'h21 + i); end
    end
    popped.delete();
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH + 2; i++) bus_store(30'h3FF, bswap(32'h30 + i), 1);
    exp_words += DEPTH;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL ovf_words: got %0d expected %0d", words, exp_words); end
    drain(DEPTH + 3);
    checks++; if (popped.size() !== DEPTH) begin errors++; $display("[TB] FAIL ovf_drain_count: got %0d expected %0d", popped.size(), DEPTH); end
    for (int i = 0; i < popped.size() && i < DEPTH; i++) begin
      checks++; if (popped[i] !== 32'h30 + 32'(i)) begin errors++; $display("[TB] FAIL ovf_word%0d: got %h expected %h", i, popped[i], 32'h30 + i); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %b expected 0", out_valid); end
    popped.delete();
  endtask

  task automatic test_end;
    logic [15:0] frozen;
    bus_store(30'h3FF, END_BUS, 1);
    exp_words++;
    checks++; if ({done, capturing} !== 2'b10) begin errors++; $display("[TB] FAIL end_state: got %b expected 10", {done, capturing}); end
    checks++; if (out_data !== END_SYM || out_last !== 1'b1) begin errors++; $display("[TB] FAIL end_head: got %h/%b expected %h/1", out_data, out_last, END_SYM); end
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL end_words: got %0d expected %0d", words, exp_words); end
    checks++; if (cycles === 16'h0) begin errors++; $display("[TB] FAIL end_cycles: got %0d expected nonzero", cycles); end
    frozen = cycles;
    repeat (4) @(negedge clk);
    bus_store(30'h3FF, bswap(32'h99), 1);
    checks++; if (cycles !== frozen) begin errors++; $display("[TB] FAIL done_cycles_frozen: got %0d expected %0d", cycles, frozen); end
    checks++; if (words !== 16'(exp_words)) begin errors++; $display("[TB] FAIL done_words: got %0d expected %0d", words, exp_words); end
    drain(3);
    checks++; if (popped.size() !== 1) begin errors++; $display("[TB] FAIL done_drain_count: got %0d expected 1", popped.size()); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL done_after_drain: got %b%b expected 01", out_valid, done); end
    popped.delete();
  endtask

  task automatic test_ignore_and_reset;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    bus_store(30'h3FE, BEGIN_BUS, 1);
    bus_store(30'h3FF, bswap(32'h7), 1);
    @(negedge clk);
    checks++; if ({capturing, done, out_valid} !== 3'b000) begin errors++; $display("[TB] FAIL idle_ignore: got %b expected 000", {capturing, done, out_valid}); end
    checks++; if (words !== 16'h0) begin errors++; $display("[TB] FAIL idle_words: got %0d expected 0", words); end
    bus_store(30'h3FF, BEGIN_BUS, 1);
    bus_store(30'h3FE, bswap(32'h8), 1);
    bus_store(30'h3FF, bswap(32'h1), 1);
    bus_store(30'h3FF, bswap(32'h2), 1);
    checks++; if (capturing !== 1'b1 || words !== 16'd2) begin errors++; $display("[TB] FAIL pre_reset: got %b/%0d expected 1/2", capturing, words); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({capturing, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL async_reset_state: got %b expected 00", {capturing, out_valid}); end
    checks++; if ({cycles, words} !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_counters: got %h expected 0", {cycles, words}); end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_full_push_pop();
    test_overflow();
    test_end();
    test_ignore_and_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
